// File: rtl/osd_ctrl.sv
// OSD character-RAM controller: arbitrates one single-port RAM between display
// prefetch, full-screen clear and host writes; also frame-syncs the OSD enable.
module osd_ctrl #(
    parameter logic [7:0] C_clear_char = 8'h20,
    parameter int         C_cells      = 1024
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic       clk_pixel_ena,
    input  logic       i_vsync,
    input  logic [9:0] i_osd_x,
    input  logic [9:0] i_osd_y,
    input  logic       i_wr_valid,
    input  logic [9:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ready,
    input  logic       i_clr,
    input  logic       i_en_req,
    output logic       o_osd_en,
    output logic [9:0] o_ram_addr,
    output logic       o_ram_we,
    output logic [7:0] o_ram_wdata,
    input  logic [7:0] i_ram_rdata,
    output logic [7:0] o_char,
    output logic       o_char_valid,
    output logic       o_busy
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [9:0] LP_LAST = 10'(C_cells - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_clr_cnt;
    logic [9:0] w_clr_cnt_nxt;
    logic       w_fetch;
    logic [4:0] w_col_nxt;
    logic [9:0] w_fetch_addr;
    logic       w_wr_acc;
    logic       r_fetch_p1;
    logic       r_vsync_p1;
    logic       r_en_shadow;
    logic       w_unused;

    // Prefetch the cell to the right while the last pixel of the current glyph is shown.
    assign w_fetch      = rst_n & clk_pixel_ena & (i_osd_x[2:0] == 3'd7);
    assign w_col_nxt    = i_osd_x[7:3] + 5'd1;
    assign w_fetch_addr = {i_osd_y[7:3], w_col_nxt};
    assign w_unused     = ^{i_osd_x[9:8], i_osd_y[9:8]};

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_wr_acc      = 1'b0;
        o_wr_ready    = 1'b0;
        o_busy        = 1'b0;
        o_ram_addr    = '0;
        o_ram_we      = 1'b0;
        o_ram_wdata   = '0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    o_wr_ready = ~w_fetch;
                    w_wr_acc   = i_wr_valid & ~w_fetch;
                    if (i_clr) begin
                        w_state_nxt   = ST_CLEAR;
                        w_clr_cnt_nxt = '0;
                    end
                end
                ST_CLEAR: begin
                    o_busy = 1'b1;
                    if (!w_fetch) begin
                        w_clr_cnt_nxt = r_clr_cnt + 10'd1;
                        if (r_clr_cnt == LP_LAST) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase

            // Fixed priority: display fetch, then clear, then host write.
            if (w_fetch) begin
                o_ram_addr = w_fetch_addr;
            end else if (r_state == ST_CLEAR) begin
                o_ram_addr  = r_clr_cnt;
                o_ram_we    = 1'b1;
                o_ram_wdata = C_clear_char;
            end else if (w_wr_acc) begin
                o_ram_addr  = i_wr_addr;
                o_ram_we    = 1'b1;
                o_ram_wdata = i_wr_data;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_fetch_p1   <= 1'b0;
            r_vsync_p1   <= 1'b0;
            r_en_shadow  <= 1'b0;
            o_osd_en     <= 1'b0;
            o_char       <= '0;
            o_char_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            // Stage p1: RAM data for last clock's fetch is valid now; capture it.
            r_fetch_p1   <= w_fetch;
            o_char_valid <= r_fetch_p1;
            if (r_fetch_p1) begin
                o_char <= i_ram_rdata;
            end
            r_vsync_p1  <= i_vsync;
            r_en_shadow <= i_en_req;
            if (i_vsync && !r_vsync_p1) begin
                o_osd_en <= r_en_shadow;
            end
        end
    end

endmodule

// File: tb/tb_osd_ctrl.sv
// Self-checking bench for osd_ctrl: bench-side RAM, cycle model and directed vectors.
module tb_osd_ctrl;

    localparam logic [7:0] CLR_CH = 8'h20;
    localparam int         CELLS  = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       vsync = 1'b0;
    logic [9:0] osd_x = '0;
    logic [9:0] osd_y = '0;
    logic       wr_valid = 1'b0;
    logic [9:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       clr = 1'b0;
    logic       en_req = 1'b0;
    logic       o_wr_ready, o_osd_en, o_ram_we, o_char_valid, o_busy;
    logic [9:0] o_ram_addr;
    logic [7:0] o_ram_wdata, o_char;
    logic [7:0] ram_rdata = '0;

    logic [7:0] mem     [CELLS];
    logic [7:0] ref_mem [CELLS];

    int n_asserts = 0;
    int n_fail    = 0;

    // Model state
    logic       m_clearing = 1'b0;
    int         m_idx = 0;
    logic       m_osd_en = 1'b0, m_shadow = 1'b0, m_prev_vs = 1'b0;
    logic       m_cv = 1'b0, m_pend = 1'b0;
    logic [7:0] m_char = '0, m_pend_char = '0;

    osd_ctrl #(.C_clear_char(CLR_CH), .C_cells(CELLS)) dut (
        .clk_pixel    (clk),
        .rst_n        (rst_n),
        .clk_pixel_ena(ena),
        .i_vsync      (vsync),
        .i_osd_x      (osd_x),
        .i_osd_y      (osd_y),
        .i_wr_valid   (wr_valid),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_ready   (o_wr_ready),
        .i_clr        (clr),
        .i_en_req     (en_req),
        .o_osd_en     (o_osd_en),
        .o_ram_addr   (o_ram_addr),
        .o_ram_we     (o_ram_we),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_char       (o_char),
        .o_char_valid (o_char_valid),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write, 1-clock read latency.
    always @(posedge clk) begin
        ram_rdata <= mem[o_ram_addr];
        if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle model: checks outputs mid-cycle, then advances across the coming edge.
    always @(negedge clk) begin
        int   xi, yi, faddr, exp_addr;
        logic fetch, exp_we;
        logic [7:0] exp_data;
        if (!rst_n) begin
            check("rst_ram_we", o_ram_we, 0);
            check("rst_ram_addr", o_ram_addr, 0);
            check("rst_busy", o_busy, 0);
            check("rst_wr_ready", o_wr_ready, 0);
            check("rst_osd_en", o_osd_en, 0);
            check("rst_char_valid", o_char_valid, 0);
            check("rst_char", o_char, 0);
            m_clearing = 0; m_idx = 0; m_osd_en = 0; m_shadow = 0; m_prev_vs = 0;
            m_cv = 0; m_char = 0; m_pend = 0;
        end else begin
            xi    = int'(osd_x);
            yi    = int'(osd_y);
            fetch = ena && (xi % 8 == 7);
            faddr = ((yi / 8) % 32) * 32 + ((xi / 8) % 32 + 1) % 32;
            exp_we = 0; exp_addr = 0; exp_data = 0;
            if (fetch) begin
                exp_addr = faddr;
            end else if (m_clearing) begin
                exp_we = 1; exp_addr = m_idx; exp_data = CLR_CH;
            end else if (wr_valid) begin
                exp_we = 1; exp_addr = int'(wr_addr); exp_data = wr_data;
            end
            check("m_ram_we", o_ram_we, exp_we);
            if (fetch || exp_we) check("m_ram_addr", o_ram_addr, exp_addr);
            if (exp_we) check("m_ram_wdata", o_ram_wdata, exp_data);
            check("m_wr_ready", o_wr_ready, !m_clearing && !fetch);
            check("m_busy", o_busy, m_clearing);
            check("m_osd_en", o_osd_en, m_osd_en);
            check("m_char_valid", o_char_valid, m_cv);
            check("m_char", o_char, m_char);

            if (exp_we) ref_mem[exp_addr] = exp_data;
            m_cv = m_pend;
            if (m_pend) m_char = m_pend_char;
            m_pend = fetch;
            if (fetch) m_pend_char = ref_mem[faddr];
            if (m_clearing) begin
                if (!fetch) begin
                    m_idx++;
                    if (m_idx == CELLS) m_clearing = 0;
                end
            end else if (clr) begin
                m_clearing = 1; m_idx = 0;
            end
            if (vsync && !m_prev_vs) m_osd_en = m_shadow;
            m_shadow  = en_req;
            m_prev_vs = vsync;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [9:0] a, input logic [7:0] d);
        bit ok = 0;
        tick();
        wr_valid = 1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_wr_ready) begin
                check("hw_we", o_ram_we, 1);
                check("hw_addr", o_ram_addr, a);
                ok = 1;
                break;
            end
        end
        if (!ok) check("hw_timeout", 0, 1);
        tick();
        wr_valid = 0;
    endtask

    function automatic int count_not_clear();
        int bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] != CLR_CH) bad++;
        return bad;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, nf;
        bit done;
        for (int i = 0; i < CELLS; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        #1 rst_n = 0;
        #2;
        check("reset_busy", o_busy, 0);
        check("reset_ram_we", o_ram_we, 0);
        check("reset_ram_addr", o_ram_addr, 0);
        check("reset_osd_en", o_osd_en, 0);
        check("reset_char_valid", o_char_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        host_write(10'd34, 8'hA5);
        host_write(10'd0, 8'h5A);
        host_write(10'd1023, 8'h3C);

        // Fetch at x=15,y=9 -> cell 34
        tick(); ena = 1; osd_x = 15; osd_y = 9;
        @(negedge clk);
        check("fetch_addr", o_ram_addr, 34);
        check("fetch_we", o_ram_we, 0);
        tick(); ena = 0;
        tick();
        @(negedge clk);
        check("fetch_char", o_char, 8'hA5);
        check("fetch_char_valid", o_char_valid, 1);

        // Column wrap: x=255,y=0 -> cell 0
        tick(); ena = 1; osd_x = 255; osd_y = 0;
        @(negedge clk);
        check("wrap_addr", o_ram_addr, 0);
        tick(); ena = 0;
        tick();
        @(negedge clk);
        check("wrap_char", o_char, 8'h5A);

        // Write colliding with a fetch
        tick(); ena = 1; osd_x = 7; osd_y = 0; wr_valid = 1; wr_addr = 500; wr_data = 8'h77;
        @(negedge clk);
        check("coll_ready", o_wr_ready, 0);
        tick(); ena = 0;
        @(negedge clk);
        check("coll_we", o_ram_we, 1);
        check("coll_addr", o_ram_addr, 500);
        check("coll_data", o_ram_wdata, 8'h77);
        tick(); wr_valid = 0;

        // Clear with no fetches; same-cycle host write; second i_clr ignored
        tick(); clr = 1; wr_valid = 1; wr_addr = 7; wr_data = 8'h11;
        @(negedge clk);
        check("clr_same_cycle_we", o_ram_we, 1);
        check("clr_same_cycle_addr", o_ram_addr, 7);
        tick(); clr = 0; wr_valid = 0;
        cnt = 0; done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!o_busy) begin done = 1; break; end
            cnt++;
            @(posedge clk); #1;
            clr = (cnt == 500);
        end
        clr = 0;
        check("clear_done", done, 1);
        check("clear_busy_len", cnt, 1024);
        check("clear_ready_after", o_wr_ready, 1);
        check("clear_cells", count_not_clear(), 0);

        // Clear with a fetch every 8th clock
        host_write(10'd300, 8'h99);
        tick(); clr = 1; ena = 1; osd_x = 0; osd_y = 0;
        cnt = 0; nf = 0; done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            clr = 0;
            osd_x = 10'((int'(osd_x) + 1) % 256);
            @(negedge clk);
            if (!o_busy) begin done = 1; break; end
            cnt++;
            if (int'(osd_x) % 8 == 7) nf++;
        end
        tick(); ena = 0;
        check("fclear_done", done, 1);
        check("fclear_nonfetch_cycles", cnt - nf, 1024);
        check("fclear_had_fetches", nf > 0, 1);
        check("fclear_cells", count_not_clear(), 0);

        // Frame-synchronous enable
        tick(); en_req = 1;
        repeat (5) tick();
        @(negedge clk);
        check("en_midframe", o_osd_en, 0);
        tick(); vsync = 1;
        @(negedge clk);
        check("en_before_edge", o_osd_en, 0);
        tick();
        @(negedge clk);
        check("en_after_edge", o_osd_en, 1);
        tick(); en_req = 0;
        repeat (3) tick();
        @(negedge clk);
        check("en_hold_high_vsync", o_osd_en, 1);
        tick(); vsync = 0;
        tick(); vsync = 1;
        tick();
        @(negedge clk);
        check("en_off_at_edge", o_osd_en, 0);
        tick(); vsync = 0;

        // Reset in the middle of a clear
        host_write(10'd50, 8'h66);
        host_write(10'd1000, 8'hEE);
        tick(); clr = 1;
        tick(); clr = 0;
        repeat (100) tick();
        check("midclear_busy", o_busy, 1);
        rst_n = 0;
        #1;
        check("abort_busy", o_busy, 0);
        check("abort_we", o_ram_we, 0);
        check("abort_addr", o_ram_addr, 0);
        repeat (2) tick();
        rst_n = 1;
        tick();
        check("abort_cell50", mem[50], CLR_CH);
        check("abort_cell1000", mem[1000], 8'hEE);
        check("abort_ready", o_wr_ready, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/osd_ctrl.md
OSD_CTRL -- requirements
Module: osd_ctrl

Interface
REQ-001 SHALL have parameter C_clear_char, default 8'h20, meaning the code written to every cell by a clear sequence.
REQ-002 SHALL have parameter C_cells, default 1024, meaning the number of character cells (32x32 grid of 8x8 glyphs over a 256x256 window).
REQ-003 SHALL have port clk_pixel, input, 1 bit: the only clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk_pixel_ena, input, 1 bit: pixel advance strobe.
REQ-006 SHALL have port i_vsync, input, 1 bit: vertical sync, active high.
REQ-007 SHALL have ports i_osd_x and i_osd_y, input, 10 bits each: OSD-relative pixel coordinates.
REQ-008 SHALL have ports i_wr_valid (1), i_wr_addr (10) and i_wr_data (8), inputs: host cell-write request.
REQ-009 SHALL have port o_wr_ready, output, 1 bit: host write accepted this cycle when high together with i_wr_valid.
REQ-010 SHALL have port i_clr, input, 1 bit: single-cycle pulse requesting a full-screen clear.
REQ-011 SHALL have port i_en_req, input, 1 bit: requested OSD enable.
REQ-012 SHALL have port o_osd_en, output, 1 bit: frame-synchronous OSD enable.
REQ-013 SHALL have ports o_ram_addr (10), o_ram_we (1) and o_ram_wdata (8), outputs: single-port character RAM command.
REQ-014 SHALL have port i_ram_rdata, input, 8 bits: RAM read data, synchronous, 1-clock latency.
REQ-015 SHALL have ports o_char (8) and o_char_valid (1), outputs: prefetched character code and its 1-clock strobe.
REQ-016 SHALL have port o_busy, output, 1 bit: high while a clear is in progress.

Function
REQ-017 SHALL arbitrate the one RAM port among three requesters, in fixed priority: display fetch, then clear, then host write.
REQ-018 SHALL issue a display fetch on every clock where clk_pixel_ena=1 and i_osd_x[2:0]=7, with address {i_osd_y[7:3], i_osd_x[7:3]+1} and the 5-bit column wrapping from 31 to 0.
REQ-019 SHALL drive o_ram_addr, o_ram_we and o_ram_wdata combinationally from the arbiter winner, with o_ram_we=0 on fetch and idle cycles.
REQ-020 SHALL register i_ram_rdata into o_char on the clock after a fetch, pulse o_char_valid for that clock, and hold o_char otherwise.
REQ-021 SHALL implement a state machine with states IDLE and CLEAR.
REQ-022 In IDLE, o_wr_ready SHALL equal the inverse of the display-fetch condition; a write is accepted when i_wr_valid and o_wr_ready are both high.
REQ-023 An i_clr pulse in IDLE SHALL move the block to CLEAR and zero the clear counter; a host write accepted in that same cycle SHALL still be performed.
REQ-024 In CLEAR, each cycle without a fetch SHALL write C_clear_char to the address held in the 10-bit clear counter and then increment the counter.
REQ-025 On the write to address C_cells-1, the block SHALL return to IDLE; the last write SHALL occur exactly C_cells non-fetch cycles after entering CLEAR.
REQ-026 During CLEAR, o_wr_ready SHALL be 0 and o_busy SHALL be 1; an i_clr pulse received during CLEAR SHALL be ignored.
REQ-027 SHALL sample i_en_req into a shadow register every clock and copy it to o_osd_en only on the rising edge of i_vsync, detected against the previous clock's i_vsync.
REQ-028 Host writes to any address, including 0 and 1023, SHALL be taken as given, with no range checking.

Reset
REQ-029 While rst_n=0, all of the following SHALL hold: state=IDLE; clear counter=0; o_osd_en=0; shadow enable=0; o_char=0; o_char_valid=0; o_busy=0; previous-vsync register=0.
REQ-030 The RAM port outputs SHALL be idle during reset: o_ram_we=0 and o_ram_addr=0.
REQ-031 Reset asserted during CLEAR SHALL abort the clear immediately, leaving RAM contents partially cleared.
REQ-032 The first arbitration SHALL take place on the first clk_pixel rising edge after rst_n deasserts.

Verification
REQ-033 Fetch: clk_pixel_ena=1, i_osd_x=15, i_osd_y=9 -> o_ram_addr=10'd34 with o_ram_we=0; next clock o_char equals the RAM content at 34 and o_char_valid=1.
REQ-034 Column wrap: i_osd_x=255, i_osd_y=0, ena=1 -> fetch address 0.
REQ-035 Write collision: i_wr_valid=1 in the same cycle as a fetch -> o_wr_ready=0; the next cycle the write is accepted with o_ram_we=1, correct addr and data.
REQ-036 Clear: i_clr pulse with clk_pixel_ena held at 0 -> o_busy=1 for exactly 1024 clocks, all cells read back 8'h20, then o_busy=0 and o_wr_ready=1.
REQ-037 Clear with fetches: i_clr with clk_pixel_ena=1 every clock and i_osd_x counting -> the clear pauses on fetch cycles only and still completes all 1024 cells.
REQ-038 Enable sync: i_en_req 0->1 mid-frame -> o_osd_en stays 0 until the clock after the i_vsync rising edge, then becomes 1; rst_n pulse mid-clear -> o_busy=0 immediately.
